// File: rtl/ctrl_pipe.sv
// Purpose : 5-stage RISC-V control path: ID decode, hazard/stall control, ID/EX, EX/MEM and MEM/WB control registers.
// Latency : ID decode and pc_src/IF_flush/pc_write are combinational; control registers advance one stage per clk.
// Backpres: stall_i freezes every register; a multi-cycle MUL or a load-use hazard holds the front end.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   IF_ID_inst        - instruction currently in ID
//   br_eq, stall_i    - ID register compare result, external memory-busy freeze
//   alu_op..imm_sel   - combinational ID-stage decode
//   ex_*, mem_*, wb_* - ID/EX, EX/MEM, MEM/WB control registers
//   pc_write, if_id_write, pc_src, IF_flush, busy - front-end pipeline control
module ctrl_pipe #(
  parameter int EN_MUL  = 1,
  parameter int MUL_LAT = 3,
  parameter int REG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       IF_ID_inst,
  input  logic              br_eq,
  input  logic              stall_i,
  // ID-stage decode
  output logic [1:0]        alu_op,
  output logic              alu_src,
  output logic              branch,
  output logic              mem_read,
  output logic              mem_write,
  output logic              reg_write,
  output logic              mem_to_reg,
  output logic [2:0]        imm_sel,
  // ID/EX
  output logic [1:0]        ex_alu_op,
  output logic              ex_alu_src,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic              ex_mul,
  output logic [REG_AW-1:0] ex_rd,
  // EX/MEM
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_reg_write,
  output logic              mem_mem_to_reg,
  output logic [REG_AW-1:0] mem_rd,
  // MEM/WB
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [REG_AW-1:0] wb_rd,
  // pipeline control
  output logic              pc_write,
  output logic              if_id_write,
  output logic              pc_src,
  output logic              IF_flush,
  output logic              busy
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MUL_WAIT = 1'b1;

  // MUL decode is enabled; the stall FSM is only needed when a MUL takes more than one EX cycle.
  localparam logic       MUL_EN   = (EN_MUL != 0);
  localparam logic       MUL_ON   = (EN_MUL != 0) && (MUL_LAT > 1);
  localparam int         LAT_M2_I = (MUL_LAT > 1) ? (MUL_LAT - 2) : 0;
  localparam logic [3:0] LAT_M2   = 4'(LAT_M2_I);

  typedef struct packed {
    logic [1:0]        alu_op;
    logic              alu_src;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mul;
    logic [REG_AW-1:0] rd;
  } idex_t;

  typedef struct packed {
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] rd;
  } memwb_t;

  // instruction fields
  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic [6:0]        w_funct7;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic [REG_AW-1:0] w_rd;
  logic              w_is_mul;

  // decode
  logic [1:0]        w_alu_op;
  logic              w_alu_src;
  logic              w_branch;
  logic              w_mem_read;
  logic              w_mem_write;
  logic              w_reg_write;
  logic              w_mem_to_reg;
  logic [2:0]        w_imm_sel;
  logic              w_id_mul;

  // hazard control
  logic              w_taken;
  logic              w_load_use;
  logic              w_mul_hold;
  logic              w_hold;
  logic              w_idex_load;

  // state
  idex_t             r_idex;
  exmem_t            r_exmem;
  memwb_t            r_memwb;
  logic [0:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_done;

  assign w_opcode = IF_ID_inst[6:0];
  assign w_funct3 = IF_ID_inst[14:12];
  assign w_funct7 = IF_ID_inst[31:25];
  assign w_rs1    = REG_AW'(IF_ID_inst[19:15]);
  assign w_rs2    = REG_AW'(IF_ID_inst[24:20]);
  assign w_rd     = REG_AW'(IF_ID_inst[11:7]);
  assign w_is_mul = (w_funct7 == 7'b0000001) && (w_funct3 == 3'b000);

  // ---------------------------------------------------------------- decode
  always_comb begin
    w_alu_op     = 2'b00;
    w_alu_src    = 1'b0;
    w_branch     = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_imm_sel    = 3'd0;
    w_id_mul     = 1'b0;
    case (w_opcode)
      OP_R: begin
        // A MUL with the M-extension disabled is treated as an illegal op (NOP).
        if (!(w_is_mul && !MUL_EN)) begin
          w_alu_op    = 2'b10;
          w_reg_write = 1'b1;
          w_id_mul    = w_is_mul & MUL_EN;
        end
      end
      OP_I_ALU: begin
        w_alu_op    = 2'b11;
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
      end
      OP_LOAD: begin
        w_alu_src    = 1'b1;
        w_mem_read   = 1'b1;
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      OP_STORE: begin
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
        w_imm_sel   = 3'd1;
      end
      OP_BRANCH: begin
        w_alu_op  = 2'b01;
        w_branch  = 1'b1;
        w_imm_sel = 3'd2;
      end
      OP_LUI: begin
        w_alu_op    = 2'b11;
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
        w_imm_sel   = 3'd3;
      end
      default: ;
    endcase
  end

  assign alu_op     = w_alu_op;
  assign alu_src    = w_alu_src;
  assign branch     = w_branch;
  assign mem_read   = w_mem_read;
  assign mem_write  = w_mem_write;
  assign reg_write  = w_reg_write;
  assign mem_to_reg = w_mem_to_reg;
  assign imm_sel    = w_imm_sel;

  // --------------------------------------------------------- hazard control
  assign w_taken = w_branch &
                   (((w_funct3 == 3'b000) &  br_eq) |
                    ((w_funct3 == 3'b001) & ~br_eq));

  assign w_load_use = r_idex.mem_read & (r_idex.rd != '0) &
                      ((r_idex.rd == w_rs1) | (r_idex.rd == w_rs2));

  // In RUN the hold starts on the first EX cycle of a fresh MUL; r_done masks the
  // final cycle of a MUL that has already waited. In MUL_WAIT a zero count only
  // occurs for MUL_LAT=2 and means the MUL leaves EX this cycle.
  always_comb begin
    w_mul_hold = 1'b0;
    case (r_state)
      ST_RUN:      w_mul_hold = MUL_ON & r_idex.mul & ~r_done;
      ST_MUL_WAIT: w_mul_hold = (r_cnt != 4'd0);
      default:     w_mul_hold = 1'b0;
    endcase
  end

  assign w_hold      = stall_i | w_mul_hold | w_load_use;
  assign w_idex_load = ~stall_i & ~w_mul_hold;

  assign pc_write    = ~w_hold;
  assign if_id_write = ~w_hold;
  assign pc_src      = w_taken & ~w_hold;
  assign IF_flush    = w_taken & ~w_hold;
  assign busy        = (r_state == ST_MUL_WAIT) | w_mul_hold;

  // ------------------------------------------------------------- MUL FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= 4'd0;
      r_done  <= 1'b0;
    end else if (!stall_i) begin
      case (r_state)
        ST_RUN: begin
          if (w_mul_hold) begin
            r_cnt   <= LAT_M2;
            r_state <= ST_MUL_WAIT;
          end
        end
        ST_MUL_WAIT: begin
          if (r_cnt <= 4'd1) begin
            r_cnt   <= 4'd0;
            r_state <= ST_RUN;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= ST_RUN;
      endcase
      // The MUL still sits in EX for one RUN cycle after the wait; remember that
      // it has been served until ID/EX takes a new entry.
      if (w_idex_load) begin
        r_done <= 1'b0;
      end else if ((r_state == ST_MUL_WAIT) && (r_cnt == 4'd1)) begin
        r_done <= 1'b1;
      end
    end
  end

  // ----------------------------------------------------- pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idex  <= '0;
      r_exmem <= '0;
      r_memwb <= '0;
    end else if (!stall_i) begin
      r_memwb.reg_write  <= r_exmem.reg_write;
      r_memwb.mem_to_reg <= r_exmem.mem_to_reg;
      r_memwb.rd         <= r_exmem.rd;

      if (w_mul_hold) begin
        // MUL keeps EX; a bubble drains into MEM behind it.
        r_exmem <= '0;
      end else begin
        r_exmem.mem_read   <= r_idex.mem_read;
        r_exmem.mem_write  <= r_idex.mem_write;
        r_exmem.reg_write  <= r_idex.reg_write;
        r_exmem.mem_to_reg <= r_idex.mem_to_reg;
        r_exmem.rd         <= r_idex.rd;
      end

      if (w_mul_hold) begin
        r_idex <= r_idex;
      end else if (w_load_use) begin
        r_idex <= '0;
      end else begin
        r_idex.alu_op     <= w_alu_op;
        r_idex.alu_src    <= w_alu_src;
        r_idex.mem_read   <= w_mem_read;
        r_idex.mem_write  <= w_mem_write;
        r_idex.reg_write  <= w_reg_write;
        r_idex.mem_to_reg <= w_mem_to_reg;
        r_idex.mul        <= w_id_mul;
        r_idex.rd         <= w_rd;
      end
    end
  end

  assign ex_alu_op      = r_idex.alu_op;
  assign ex_alu_src     = r_idex.alu_src;
  assign ex_mem_read    = r_idex.mem_read;
  assign ex_mem_write   = r_idex.mem_write;
  assign ex_reg_write   = r_idex.reg_write;
  assign ex_mem_to_reg  = r_idex.mem_to_reg;
  assign ex_mul         = r_idex.mul;
  assign ex_rd          = r_idex.rd;

  assign mem_mem_read   = r_exmem.mem_read;
  assign mem_mem_write  = r_exmem.mem_write;
  assign mem_reg_write  = r_exmem.reg_write;
  assign mem_mem_to_reg = r_exmem.mem_to_reg;
  assign mem_rd         = r_exmem.rd;

  assign wb_reg_write   = r_memwb.reg_write;
  assign wb_mem_to_reg  = r_memwb.mem_to_reg;
  assign wb_rd          = r_memwb.rd;

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 The block SHALL have parameter EN_MUL, default 1, which enables M-extension MUL decode and the multi-cycle stall.
REQ-002 The block SHALL have parameter MUL_LAT, default 3, giving total EX-stage cycles for a MUL (legal range 1..15).
REQ-003 The block SHALL have parameter REG_AW, default 5, giving the register-address width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port IF_ID_inst, input, 32, the instruction in ID.
REQ-007 The block SHALL have port br_eq, input, 1, the ID-stage register compare result (rs1 == rs2).
REQ-008 The block SHALL have port stall_i, input, 1, external memory-busy freeze.
REQ-009 The block SHALL have ports alu_op[1:0], alu_src, branch, mem_read, mem_write, reg_write, mem_to_reg and imm_sel[2:0], all outputs carrying ID-stage decode.
REQ-010 The block SHALL have ports ex_alu_op[1:0], ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_mul and ex_rd[REG_AW-1:0], all outputs forming the ID/EX control register.
REQ-011 The block SHALL have ports mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg and mem_rd, all outputs forming the EX/MEM control register.
REQ-012 The block SHALL have ports wb_reg_write, wb_mem_to_reg and wb_rd, all outputs forming the MEM/WB control register.
REQ-013 The block SHALL have ports pc_write, if_id_write, pc_src, IF_flush and busy, all 1-bit outputs for pipeline control.

Function
REQ-014 The decoder SHALL be combinational on IF_ID_inst[6:0], with alu_op encoded 00 add, 01 branch, 10 R-type, 11 I/U-type, and imm_sel encoded 0 I, 1 S, 2 B, 3 U.
REQ-015 Decode SHALL be: R-type 0110011 gives alu_op 10 and reg_write; I-ALU 0010011 gives alu_op 11, alu_src and reg_write; load 0000011 gives alu_op 00, alu_src, mem_read, reg_write and mem_to_reg; store 0100011 gives alu_op 00, alu_src and mem_write, imm_sel 1; branch 1100011 gives alu_op 01 and branch, imm_sel 2; LUI 0110111 gives alu_op 11, alu_src and reg_write, imm_sel 3.
REQ-016 Any other opcode, and MUL when EN_MUL=0, SHALL decode to all-zero controls (NOP).
REQ-017 MUL SHALL be R-type with funct7=0000001 and funct3=000, and SHALL set an internal id_mul flag.
REQ-018 The branch-taken term SHALL be branch & ((funct3==000 & br_eq) | (funct3==001 & ~br_eq)).
REQ-019 pc_src and IF_flush SHALL both equal the branch-taken term gated by ~hold, with no latency, where hold = stall_i | mul_hold | load_use.
REQ-020 load_use SHALL be ex_mem_read & (ex_rd != 0) & (ex_rd == rs1 | ex_rd == rs2) from IF_ID_inst.
REQ-021 pc_write and if_id_write SHALL both equal ~hold.
REQ-022 When stall_i=1, all ID/EX, EX/MEM and MEM/WB registers and the FSM SHALL hold their values.
REQ-023 When mul_hold=1 and stall_i=0, ID/EX SHALL hold, a bubble (all control zero, rd 0) SHALL enter EX/MEM, and MEM/WB SHALL advance.
REQ-024 When load_use=1 and no other hold is active, a bubble SHALL enter ID/EX and EX/MEM and MEM/WB SHALL advance.
REQ-025 With no hold active, all three registers SHALL advance, and ID/EX SHALL load the decode, id_mul and rd=IF_ID_inst[11:7].
REQ-026 The FSM SHALL have states RUN and MUL_WAIT, with a counter of 4 bits.
REQ-027 In RUN, when ex_mul=1, EN_MUL=1, MUL_LAT>1 and stall_i=0, the FSM SHALL load the counter with MUL_LAT-2 and go to MUL_WAIT.
REQ-028 mul_hold SHALL be 1 in RUN on that entry cycle and 1 in MUL_WAIT.
REQ-029 In MUL_WAIT, when stall_i=0, the counter SHALL decrement, and when the counter reaches 0 the FSM SHALL go to RUN with mul_hold=0 in that cycle, so ex_mul advances.
REQ-030 On return to RUN, a MUL advancing out of EX SHALL NOT retrigger the FSM, tracked by a one-shot done flag cleared when ID/EX reloads.
REQ-031 busy SHALL equal (state==MUL_WAIT) | mul_hold.
REQ-032 The priority SHALL be stall_i > mul_hold > load_use > branch.

Reset
REQ-033 While rst_n=0, all pipeline-register outputs, the counter and the done flag SHALL be 0, the FSM SHALL be in RUN, and busy SHALL be 0.
REQ-034 Assertion of rst_n SHALL take effect immediately and asynchronously, including mid-MUL_WAIT, which SHALL abort to RUN.
REQ-035 Deassertion of rst_n SHALL be taken on a clk edge, with the first decode in the following cycle.

Verification
REQ-036 Bench SHALL drive LW x5 in EX then ADD x6,x5,x1 in ID and require load_use=1, pc_write=0 for 1 cycle and ex_reg_write=0 in the next cycle.
REQ-037 Bench SHALL drive BEQ with br_eq=1 and require pc_src=IF_flush=1 in the same cycle; with br_eq=0 both SHALL be 0; BNE SHALL give the inverse.
REQ-038 Bench SHALL run MUL x7 with MUL_LAT=3 and require busy=1 for 2 cycles, ex_mul=1 for 3 cycles and mem_reg_write=1 with mem_rd=7 exactly once.
REQ-039 Bench SHALL assert stall_i=1 during MUL_WAIT for 2 cycles and require the counter frozen and the total MUL occupancy of EX to be 5 cycles.
REQ-040 Bench SHALL pulse rst_n=0 mid-MUL_WAIT and require all outputs 0 and state RUN without a clock.
REQ-041 Bench SHALL drive opcode 1110011 and require all ID controls 0; with EN_MUL=0, MUL SHALL give reg_write=0.
